free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list.sv | 125 ++++++++++++
 tb/tb_free_list.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list: a circular FIFO of free tags.
// Dispatch allocates from the head and retire returns tags at the tail.
module free_list #(
  parameter int PHYS_REG_SZ = 64,
  parameter int ARCH_REG_SZ = 32
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       alloc_en,
  output logic [$clog2(PHYS_REG_SZ)-1:0]             alloc_tag,
  output logic                                       alloc_valid,
  input  logic                                       free_en,
  input  logic [$clog2(PHYS_REG_SZ)-1:0]             free_tag,
  output logic [$clog2(PHYS_REG_SZ-ARCH_REG_SZ):0]   free_count,
  output logic                                       overflow_err
);

  localparam int N     = PHYS_REG_SZ - ARCH_REG_SZ;
  localparam int TAG_W = $clog2(PHYS_REG_SZ);
  localparam int PTR_W = $clog2(N);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_EMPTY = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // Explicit wrap so the pointer stays correct even if N were not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_LAST) begin
      r = PTR_ZERO;
    end else begin
      r = p + PTR_ONE;
    end
    return r;
  endfunction

  logic [TAG_W-1:0] entry_q [N];
  logic [TAG_W-1:0] entry_d [N];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             alloc_ok_s;
  logic             free_ok_s;

  // Acceptance: a full list can still take a free when an allocation vacates a slot.
  always_comb begin
    alloc_ok_s = 1'b0;
    free_ok_s  = 1'b0;
    if (alloc_en && (count_q != CNT_EMPTY)) begin
      alloc_ok_s = 1'b1;
    end else begin
      alloc_ok_s = 1'b0;
    end
    if (free_en && ((count_q != CNT_FULL) || alloc_ok_s)) begin
      free_ok_s = 1'b1;
    end else begin
      free_ok_s = 1'b0;
    end
  end

  // Next-state for pointers, storage, count and the sticky overflow flag.
  always_comb begin
    entry_d    = entry_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (alloc_ok_s) begin
      head_d = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end

    if (free_ok_s) begin
      entry_d[tail_q] = free_tag;
      tail_d          = ptr_inc(tail_q);
    end else begin
      tail_d = tail_q;
    end

    case ({free_ok_s, alloc_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (free_en && !free_ok_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers; reset refills the list with the tags above the architectural range.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        entry_q[i] <= TAG_W'(ARCH_REG_SZ + i);
      end
      head_q     <= PTR_ZERO;
      tail_q     <= PTR_ZERO;
      count_q    <= CNT_FULL;
      overflow_q <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign alloc_tag    = entry_q[head_q];
  assign alloc_valid  = (count_q != CNT_EMPTY);
  assign free_count   = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list with default parameters (N = 32).
module tb_free_list;

  logic       clock;
  logic       reset;
  logic       alloc_en;
  logic [5:0] alloc_tag;
  logic       alloc_valid;
  logic       free_en;
  logic [5:0] free_tag;
  logic [5:0] free_count;
  logic       overflow_err;

  int vectors;
  int miscompares;

  free_list #(.PHYS_REG_SZ(64), .ARCH_REG_SZ(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (alloc_tag),
    .alloc_valid  (alloc_valid),
    .free_en      (free_en),
    .free_tag     (free_tag),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Pulse reset between edges and check the reset image without any clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_tag", 32'(alloc_tag), 32'd32);
    chk("rst_valid", 32'(alloc_valid), 32'd1);
    chk("rst_count", 32'(free_count), 32'd32);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    alloc_en    = 1'b0;
    free_en     = 1'b0;
    free_tag    = 6'd0;

    // Reset before the first clock edge.
    #1;
    do_reset();

    // Three allocations: 32, 33, 34.
    cyc();
    alloc_en = 1'b1;
    chk("a3_tag0", 32'(alloc_tag), 32'd32);
    cyc();
    chk("a3_tag1", 32'(alloc_tag), 32'd33);
    cyc();
    chk("a3_tag2", 32'(alloc_tag), 32'd34);
    cyc();
    alloc_en = 1'b0;
    chk("a3_count", 32'(free_count), 32'd29);
    chk("a3_next", 32'(alloc_tag), 32'd35);

    // Drain the whole list.
    do_reset();
    alloc_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("drain_tag", 32'(alloc_tag), 32'(32 + i));
      chk("drain_valid", 32'(alloc_valid), 32'd1);
      cyc();
    end
    chk("empty_valid", 32'(alloc_valid), 32'd0);
    chk("empty_count", 32'(free_count), 32'd0);
    cyc();
    chk("underflow_valid", 32'(alloc_valid), 32'd0);
    chk("underflow_count", 32'(free_count), 32'd0);
    chk("underflow_ovf", 32'(overflow_err), 32'd0);

    // Free and alloc together at empty: alloc refused, tag visible next cycle.
    free_en  = 1'b1;
    free_tag = 6'd5;
    cyc();
    free_en  = 1'b0;
    alloc_en = 1'b0;
    chk("e2a_valid", 32'(alloc_valid), 32'd1);
    chk("e2a_tag", 32'(alloc_tag), 32'd5);
    chk("e2a_count", 32'(free_count), 32'd1);

    // Free into a full list is dropped and flags overflow.
    do_reset();
    free_en  = 1'b1;
    free_tag = 6'd7;
    cyc();
    free_en = 1'b0;
    chk("ovf_flag", 32'(overflow_err), 32'd1);
    chk("ovf_count", 32'(free_count), 32'd32);
    chk("ovf_tag", 32'(alloc_tag), 32'd32);
    alloc_en = 1'b1;
    cyc();
    alloc_en = 1'b0;
    chk("ovf_sticky", 32'(overflow_err), 32'd1);
    chk("ovf_alloc_count", 32'(free_count), 32'd31);
    chk("ovf_alloc_tag", 32'(alloc_tag), 32'd33);
    free_en  = 1'b1;
    free_tag = 6'd9;
    cyc();
    free_en = 1'b0;
    chk("refill_count", 32'(free_count), 32'd32);
    chk("refill_ovf", 32'(overflow_err), 32'd1);

    // Simultaneous alloc and free while full, across a wrap of both pointers.
    do_reset();
    alloc_en = 1'b1;
    free_en  = 1'b1;
    free_tag = 6'd3;
    for (int i = 0; i < 33; i++) begin
      chk("wrap_tag", 32'(alloc_tag), (i < 32) ? 32'(32 + i) : 32'd3);
      chk("wrap_count", 32'(free_count), 32'd32);
      cyc();
    end
    alloc_en = 1'b0;
    free_en  = 1'b0;
    chk("wrap_ovf", 32'(overflow_err), 32'd0);
    chk("wrap_after_tag", 32'(alloc_tag), 32'd3);

    // Asynchronous reset after ten allocations, with inputs still active.
    do_reset();
    alloc_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
    end
    chk("ar_pre_tag", 32'(alloc_tag), 32'd42);
    chk("ar_pre_count", 32'(free_count), 32'd22);
    free_en  = 1'b1;
    free_tag = 6'd11;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_tag", 32'(alloc_tag), 32'd32);
    chk("ar_count", 32'(free_count), 32'd32);
    chk("ar_ovf", 32'(overflow_err), 32'd0);
    cyc();
    chk("ar_hold_tag", 32'(alloc_tag), 32'd32);
    chk("ar_hold_count", 32'(free_count), 32'd32);
    reset    = 1'b0;
    alloc_en = 1'b0;
    free_en  = 1'b0;
    cyc();
    chk("ar_post_tag", 32'(alloc_tag), 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
